// File: rtl/mem_bank_ctrl_if.sv
// Requester-side write bus for mem_bank_ctrl: two requesters, each with its own
// address/data slice, and one ack pulse per requester.
interface mem_bank_ctrl_if #(
  parameter int WORDS = 4,
  parameter int WIDTH = 8
) ();
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [1:0]         req_i;
  logic [2*AW-1:0]    addr_i;
  logic [2*WIDTH-1:0] data_i;
  logic [1:0]         ack_o;

  modport master (output req_i, output addr_i, output data_i, input ack_o);
  modport slave  (input req_i, input addr_i, input data_i, output ack_o);
endinterface

// File: rtl/mem_bank_ctrl.sv
// Write sequencer for a bank of dual-rail latch words: NULL wave, data wave, settle, ack.
// Optional readback check of the written word is enabled by defining MEM_BANK_CTRL_RDBK_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for a request; arbitrates and captures addr/data
// ST_NULL   | target latch transparent, rails driven NULL, OPEN_CYC cycles
// ST_DATA   | target latch transparent, rails carry data, OPEN_CYC cycles
// ST_SETTLE | all latches opaque, rails NULL, SETTLE_CYC cycles
// ST_DONE   | one-cycle ack to the granted requester (optional readback)
module mem_bank_ctrl #(
  parameter int WORDS      = 4,
  parameter int WIDTH      = 8,
  parameter int OPEN_CYC   = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_bank_ctrl_if.slave           bus,
  output logic [WORDS-1:0]         lat_o,
  output logic [2*WIDTH-1:0]       rails_o,
  input  logic [WORDS*2*WIDTH-1:0] rd_rails_i,
  output logic                     busy_o,
  output logic                     err_o
);
  localparam int AW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MAXC = (OPEN_CYC > SETTLE_CYC) ? OPEN_CYC : SETTLE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_NULL, ST_DATA, ST_SETTLE, ST_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             gnt_q;
  logic             prio_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       ack_q;

  logic             gnt_nxt;
  logic [AW-1:0]    addr_nxt;
  logic [WIDTH-1:0] data_nxt;

  function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] d);
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i+1] = d[i];
      r[2*i]   = ~d[i];
    end
    return r;
  endfunction

  // Out-of-range addresses match no bit, leaving every latch opaque.
  function automatic logic [WORDS-1:0] lat_mask(input logic [AW-1:0] a);
    logic [WORDS-1:0] m;
    m = '1;
    for (int i = 0; i < WORDS; i++) begin
      if (a == AW'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  // prio_q names the requester that wins a tie.
  always_comb begin
    gnt_nxt = 1'b0;
    if (bus.req_i == 2'b11) gnt_nxt = prio_q;
    else                    gnt_nxt = bus.req_i[1];
  end

  assign addr_nxt = gnt_nxt ? bus.addr_i[2*AW-1:AW]       : bus.addr_i[AW-1:0];
  assign data_nxt = gnt_nxt ? bus.data_i[2*WIDTH-1:WIDTH] : bus.data_i[WIDTH-1:0];

`ifdef MEM_BANK_CTRL_RDBK_EN
  logic rb_bad;
  logic err_q;

  always_comb begin
    rb_bad = 1'b0;
    for (int w = 0; w < WORDS; w++) begin
      if (addr_q == AW'(w) && rd_rails_i[w*2*WIDTH +: 2*WIDTH] != enc(data_q)) rb_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_q <= 1'b0;
    else if (state_q == ST_DONE && rb_bad)  err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_rd;
  assign unused_rd = ^rd_rails_i;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 2'b00;
      lat_o   <= '1;
      rails_o <= '0;
      busy_o  <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (|bus.req_i) begin
            gnt_q   <= gnt_nxt;
            prio_q  <= ~gnt_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            cnt_q   <= CW'(OPEN_CYC - 1);
            lat_o   <= lat_mask(addr_nxt);
            rails_o <= '0;
            busy_o  <= 1'b1;
            state_q <= ST_NULL;
          end
        end
        ST_NULL: begin
          if (cnt_q == '0) begin
            cnt_q   <= CW'(OPEN_CYC - 1);
            rails_o <= enc(data_q);
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            cnt_q   <= CW'(SETTLE_CYC - 1);
            lat_o   <= '1;
            rails_o <= '0;
            state_q <= ST_SETTLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          lat_o   <= '1;
          rails_o <= '0;
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o = ack_q;
endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl: a 4-word and a 3-word instance, a behavioural
// latch bank feeding readback, and one task per scenario.
module tb_mem_bank_ctrl;
`ifdef MEM_BANK_CTRL_RDBK_EN
  localparam bit RDBK = 1'b1;
`else
  localparam bit RDBK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bank_ctrl_if #(.WORDS(4), .WIDTH(8)) bus ();
  mem_bank_ctrl_if #(.WORDS(3), .WIDTH(8)) bus3 ();

  logic [3:0]  lat;
  logic [15:0] rails;
  logic [63:0] rd_rails;
  logic        busy, err;
  logic [2:0]  lat3;
  logic [15:0] rails3;
  logic        busy3, err3;
  logic [47:0] rd_rails3;
  assign rd_rails3 = '0;

  mem_bank_ctrl #(.WORDS(4), .WIDTH(8), .OPEN_CYC(2), .SETTLE_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .lat_o(lat), .rails_o(rails),
    .rd_rails_i(rd_rails), .busy_o(busy), .err_o(err));

  mem_bank_ctrl #(.WORDS(3), .WIDTH(8), .OPEN_CYC(2), .SETTLE_CYC(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .lat_o(lat3), .rails_o(rails3),
    .rd_rails_i(rd_rails3), .busy_o(busy3), .err_o(err3));

  // Behavioural bank: a word follows the rails while its latch is transparent.
  logic [15:0] bank [4];
  logic        flip_b0 = 1'b0;
  initial for (int w = 0; w < 4; w++) bank[w] = '0;
  always @(posedge clk) for (int w = 0; w < 4; w++) if (!lat[w]) bank[w] <= rails;
  always_comb for (int w = 0; w < 4; w++) rd_rails[w*16 +: 16] = bank[w] ^ {15'b0, flip_b0};

  typedef struct { logic [1:0] ack; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [15:0] enc8(input logic [7:0] d);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++; if (lat !== 4'b1111) begin n_bad++; $display("FAIL rst_lat: got %b expected 1111", lat); end
    n_cmp++; if (rails !== 16'h0) begin n_bad++; $display("FAIL rst_rails: got %h expected 0000", rails); end
    n_cmp++; if (bus.ack_o !== 2'b00) begin n_bad++; $display("FAIL rst_ack: got %b expected 00", bus.ack_o); end
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_busy_err: got %b%b expected 00", busy, err); end
    n_cmp++; if (lat3 !== 3'b111) begin n_bad++; $display("FAIL rst_lat3: got %b expected 111", lat3); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_contention();
    int t0, got, last;
    bus.addr_i = {2'd3, 2'd1};
    bus.data_i = {8'h3C, 8'h81};
    bus.req_i  = 2'b11;
    t0 = cyc;
    sbq.push_back('{2'b01, t0 + 13});
    sbq.push_back('{2'b10, t0 + 27});
    sbq.push_back('{2'b01, t0 + 41});
    sbq.push_back('{2'b10, t0 + 55});
    got = 0;
    last = 0;
    for (int k = 0; k < 80 && got < 4; k++) begin
      step();
      if ($countones(~lat) > 1) begin n_bad++; $display("FAIL lat_onehot: got %b expected at most one 0", lat); end
      if (bus.ack_o !== 2'b00) begin
        e = sbq.pop_front();
        n_cmp++; if (bus.ack_o !== e.ack) begin n_bad++; $display("FAIL cont_ack: got %b expected %b", bus.ack_o, e.ack); end
        n_cmp++; if (cyc !== e.cyc) begin n_bad++; $display("FAIL cont_time: got %0d expected %0d", cyc - t0, e.cyc - t0); end
        if (got > 0) begin
          n_cmp++; if (cyc - last !== 14) begin n_bad++; $display("FAIL cont_gap: got %0d expected 14", cyc - last); end
        end
        last = cyc;
        got++;
        if (got == 4) bus.req_i = 2'b00;
      end
    end
    if (got < 4) begin n_cmp++; n_bad++; $display("FAIL cont_timeout: got %0d acks expected 4", got); end
    sbq.delete();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_busy: got %b expected 0", busy); end
    n_cmp++; if (bank[1] !== enc8(8'h81)) begin n_bad++; $display("FAIL cont_word1: got %h expected %h", bank[1], enc8(8'h81)); end
    n_cmp++; if (bank[3] !== enc8(8'h3C)) begin n_bad++; $display("FAIL cont_word3: got %h expected %h", bank[3], enc8(8'h3C)); end
  endtask

  task automatic test_single();
    int t0;
    bus.addr_i = {2'd0, 2'd2};
    bus.data_i = {8'h00, 8'hA5};
    bus.req_i  = 2'b01;
    t0 = cyc;
    sbq.push_back('{2'b01, t0 + 13});
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) begin
        bus.req_i  = 2'b00;
        bus.addr_i = {2'd0, 2'd1};
        bus.data_i = {8'h00, 8'h5A};
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy); end
      end
      if (k <= 4) begin
        n_cmp++; if (lat !== 4'b1011) begin n_bad++; $display("FAIL single_lat_open k=%0d: got %b expected 1011", k, lat); end
        n_cmp++; if (rails !== (k <= 2 ? 16'h0 : enc8(8'hA5))) begin n_bad++; $display("FAIL single_rails k=%0d: got %h", k, rails); end
      end else if (k <= 13) begin
        n_cmp++; if (lat !== 4'b1111 || rails !== 16'h0) begin n_bad++; $display("FAIL single_settle k=%0d: got lat %b rails %h expected 1111 0000", k, lat, rails); end
      end
      if (bus.ack_o !== 2'b00) begin
        if (sbq.size() == 0) begin n_cmp++; n_bad++; $display("FAIL single_extra_ack: got %b expected 00", bus.ack_o); end
        else begin
          e = sbq.pop_front();
          n_cmp++; if (bus.ack_o !== e.ack || cyc !== e.cyc) begin n_bad++; $display("FAIL single_ack: got %b at %0d expected %b at %0d", bus.ack_o, cyc - t0, e.ack, e.cyc - t0); end
        end
      end
      if (k == 14) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
      end
    end
    n_cmp++; if (sbq.size() !== 0) begin n_bad++; $display("FAIL single_missing_ack: got %0d pending expected 0", sbq.size()); end
    sbq.delete();
    n_cmp++; if (bank[2] !== enc8(8'hA5)) begin n_bad++; $display("FAIL single_word2: got %h expected %h", bank[2], enc8(8'hA5)); end
  endtask

  task automatic test_out_of_range();
    int t0;
    bit lat_ok;
    bus3.addr_i = {2'd0, 2'd3};
    bus3.data_i = {8'h00, 8'hFF};
    bus3.req_i  = 2'b01;
    t0 = cyc;
    sbq.push_back('{2'b01, t0 + 13});
    lat_ok = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) bus3.req_i = 2'b00;
      if (lat3 !== 3'b111) lat_ok = 1'b0;
      if (bus3.ack_o !== 2'b00) begin
        if (sbq.size() == 0) begin n_cmp++; n_bad++; $display("FAIL oor_extra_ack: got %b expected 00", bus3.ack_o); end
        else begin
          e = sbq.pop_front();
          n_cmp++; if (bus3.ack_o !== e.ack || cyc !== e.cyc) begin n_bad++; $display("FAIL oor_ack: got %b at %0d expected %b at %0d", bus3.ack_o, cyc - t0, e.ack, e.cyc - t0); end
        end
      end
    end
    n_cmp++; if (!lat_ok) begin n_bad++; $display("FAIL oor_lat: got a transparent latch expected 111 throughout"); end
    n_cmp++; if (sbq.size() !== 0) begin n_bad++; $display("FAIL oor_missing_ack: got %0d pending expected 0", sbq.size()); end
    sbq.delete();
    n_cmp++; if (busy3 !== 1'b0 || err3 !== 1'b0) begin n_bad++; $display("FAIL oor_end: got busy %b err %b expected 0 0", busy3, err3); end
  endtask

  task automatic test_mid_reset();
    int t0, got;
    bit no_ack;
    bus.addr_i = {2'd0, 2'd0};
    bus.data_i = {8'h00, 8'h77};
    bus.req_i  = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) bus.req_i = 2'b00;
    end
    n_cmp++; if (lat !== 4'b1110 || rails !== enc8(8'h77)) begin n_bad++; $display("FAIL mid_pre: got lat %b rails %h expected 1110 %h", lat, rails, enc8(8'h77)); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (lat !== 4'b1111 || rails !== 16'h0) begin n_bad++; $display("FAIL mid_async: got lat %b rails %h expected 1111 0000", lat, rails); end
    n_cmp++; if (busy !== 1'b0 || bus.ack_o !== 2'b00) begin n_bad++; $display("FAIL mid_async_ctl: got busy %b ack %b expected 0 00", busy, bus.ack_o); end
    step();
    rst_n = 1'b1;
    no_ack = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.ack_o !== 2'b00 || busy !== 1'b0) no_ack = 1'b0;
    end
    n_cmp++; if (!no_ack) begin n_bad++; $display("FAIL mid_no_ack: got activity after abort expected none"); end
    bus.addr_i = {2'd2, 2'd1};
    bus.data_i = {8'hC3, 8'h18};
    bus.req_i  = 2'b11;
    t0 = cyc;
    sbq.push_back('{2'b01, t0 + 13});
    sbq.push_back('{2'b10, t0 + 27});
    got = 0;
    for (int k = 1; k < 60 && got < 2; k++) begin
      step();
      if (k == 1) bus.req_i = 2'b10;
      if (bus.ack_o !== 2'b00) begin
        e = sbq.pop_front();
        n_cmp++; if (bus.ack_o !== e.ack || cyc !== e.cyc) begin n_bad++; $display("FAIL mid_regrant: got %b at %0d expected %b at %0d", bus.ack_o, cyc - t0, e.ack, e.cyc - t0); end
        got++;
        if (got == 2) bus.req_i = 2'b00;
      end
    end
    if (got < 2) begin n_cmp++; n_bad++; $display("FAIL mid_timeout: got %0d acks expected 2", got); end
    sbq.delete();
    step();
  endtask

  task automatic test_readback();
    int got;
    flip_b0 = 1'b1;
    bus.addr_i = {2'd0, 2'd1};
    bus.data_i = {8'h00, 8'h5A};
    bus.req_i  = 2'b01;
    got = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) bus.req_i = 2'b00;
      if (bus.ack_o !== 2'b00) begin
        got++;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rb_err_early: got %b expected 0", err); end
      end
    end
    n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL rb_ack: got %0d acks expected 1", got); end
    n_cmp++; if (err !== RDBK) begin n_bad++; $display("FAIL rb_err_set: got %b expected %b", err, RDBK); end
    flip_b0 = 1'b0;
    bus.data_i = {8'h00, 8'h66};
    bus.req_i  = 2'b01;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) bus.req_i = 2'b00;
    end
    n_cmp++; if (err !== RDBK) begin n_bad++; $display("FAIL rb_err_sticky: got %b expected %b", err, RDBK); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rb_err_clear: got %b expected 0", err); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.req_i = 2'b00;  bus.addr_i = '0;  bus.data_i = '0;
    bus3.req_i = 2'b00; bus3.addr_i = '0; bus3.data_i = '0;
    test_reset();
    test_contention();
    test_single();
    test_out_of_range();
    test_mid_reset();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
